// File: rtl/rt_ibex_pcs_pkg.sv
// rt_ibex_pcs_pkg: shared types and default sizing for the rt-ibex hardware context stack.
// Contents: state_t (stack FSM states), frame_t (one saved register frame at default sizing),
// PcsAddrW / PcsDepthW (memory address and stack-pointer widths at default depth).
package rt_ibex_pcs_pkg;

    localparam int PcsNrSavedRegs   = 9;
    localparam int PcsDataWidth     = 32;
    localparam int PcsStackDepth    = 8;
    localparam int PcsIrqLevelWidth = 8;
    localparam int PcsAddrW         = $clog2(PcsStackDepth);
    localparam int PcsDepthW        = $clog2(PcsStackDepth + 1);

    typedef enum logic [1:0] {
        IDLE,
        STORE,
        RD_REQ,
        RD_RSP
    } state_t;

    typedef logic [PcsNrSavedRegs-1:0][PcsDataWidth-1:0] frame_t;

endpackage

// File: rtl/rt_ibex_pcs_stack_mem.sv
// rt_ibex_pcs_stack_mem: Depth x Width flop array with a single read/write port.
// Ports: clk_i clock; en_i port enable; we_i write (else read); addr_i word address;
//        wdata_i write data; rdata_o read data, registered (valid the cycle after a read,
//        held until the next read). Data storage is intentionally not reset.
module rt_ibex_pcs_stack_mem #(
    parameter int Depth = 8,
    parameter int Width = 288,
    parameter int AddrW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             en_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] addr_i,
    input  logic [Width-1:0] wdata_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) mem_q[addr_i] <= wdata_i;
            else      rdata_o       <= mem_q[addr_i];
        end
    end

endmodule

// File: rtl/rt_ibex_pcs_stack.sv
// rt_ibex_pcs_stack: hardware context stack for nested interrupts on the rt-ibex core.
// Pushes one register frame per IRQ ack and pops the top frame back on the next mret.
// Ports: clk_i / rst_ni (async, active-low); irq_ack_i + irq_level_i + store_data_i push a
//        frame (data held through STORE); next_mret_i pops; restore_data_o / restore_level_o /
//        restore_en_o return the popped frame; busy_o, full_o, empty_o, depth_o report status;
//        overflow_o / underflow_o are sticky errors cleared by clear_err_i.
// Build option: define RT_IBEX_PCS_LEVEL_TAG_EN to store the IRQ level with each frame;
//               otherwise restore_level_o reads 0.
module rt_ibex_pcs_stack
    import rt_ibex_pcs_pkg::*;
#(
    parameter int NrSavedRegs   = PcsNrSavedRegs,
    parameter int DataWidth     = PcsDataWidth,
    parameter int StackDepth    = PcsStackDepth,
    parameter int IrqLevelWidth = PcsIrqLevelWidth
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               irq_ack_i,
    input  logic [IrqLevelWidth-1:0]           irq_level_i,
    input  logic [NrSavedRegs*DataWidth-1:0]   store_data_i,
    input  logic                               next_mret_i,
    output logic [NrSavedRegs*DataWidth-1:0]   restore_data_o,
    output logic [IrqLevelWidth-1:0]           restore_level_o,
    output logic                               restore_en_o,
    output logic                               busy_o,
    output logic                               full_o,
    output logic                               empty_o,
    output logic [$clog2(StackDepth+1)-1:0]    depth_o,
    output logic                               overflow_o,
    output logic                               underflow_o,
    input  logic                               clear_err_i
);

    localparam int AddrW  = $clog2(StackDepth);
    localparam int DepthW = $clog2(StackDepth + 1);
    localparam int DataW  = NrSavedRegs * DataWidth;
`ifdef RT_IBEX_PCS_LEVEL_TAG_EN
    localparam int FrameW = DataW + IrqLevelWidth;
`else
    localparam int FrameW = DataW;
`endif

    state_t            state_q, state_d;
    logic [DepthW-1:0] sp_q, sp_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              mem_en, mem_we;
    logic [AddrW-1:0]  mem_addr;
    logic [FrameW-1:0] mem_wdata, mem_rdata;

    assign full_o  = sp_q == DepthW'(StackDepth);
    assign empty_o = sp_q == '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sp_q    <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Error clear is applied first so a same-cycle new error still sets the flag.
    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        ovf_d   = ovf_q & ~clear_err_i;
        unf_d   = unf_q & ~clear_err_i;
        mem_en  = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (irq_ack_i) begin
                    if (full_o) ovf_d   = 1'b1;
                    else        state_d = STORE;
                end else if (next_mret_i) begin
                    if (empty_o) unf_d   = 1'b1;
                    else         state_d = RD_REQ;
                end
            end
            STORE: begin
                mem_en  = 1'b1;
                mem_we  = 1'b1;
                sp_d    = sp_q + 1'b1;
                state_d = IDLE;
            end
            RD_REQ: begin
                mem_en  = 1'b1;
                state_d = RD_RSP;
            end
            RD_RSP: begin
                sp_d    = sp_q - 1'b1;
                state_d = IDLE;
            end
        endcase
        mem_addr = AddrW'(state_q == STORE ? sp_q : sp_q - 1'b1);
    end

    rt_ibex_pcs_stack_mem #(
        .Depth (StackDepth),
        .Width (FrameW),
        .AddrW (AddrW)
    ) u_mem (
        .clk_i   (clk_i),
        .en_i    (mem_en),
        .we_i    (mem_we),
        .addr_i  (mem_addr),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    assign restore_en_o   = state_q == RD_RSP;
    assign restore_data_o = restore_en_o ? mem_rdata[DataW-1:0] : '0;
    assign busy_o         = state_q != IDLE;
    assign depth_o        = sp_q;
    assign overflow_o     = ovf_q;
    assign underflow_o    = unf_q;

`ifdef RT_IBEX_PCS_LEVEL_TAG_EN
    // The level only accompanies the ack pulse, so it is captured for the STORE write.
    logic [IrqLevelWidth-1:0] lvl_in_q, lvl_out_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lvl_in_q  <= '0;
            lvl_out_q <= '0;
        end else begin
            if (state_q == IDLE && irq_ack_i) lvl_in_q <= irq_level_i;
            if (restore_en_o) lvl_out_q <= mem_rdata[FrameW-1 -: IrqLevelWidth];
        end
    end

    assign mem_wdata       = {lvl_in_q, store_data_i};
    assign restore_level_o = restore_en_o ? mem_rdata[FrameW-1 -: IrqLevelWidth] : lvl_out_q;
`else
    assign mem_wdata       = store_data_i;
    // Masking keeps the level input referenced while the tag is compiled out.
    assign restore_level_o = irq_level_i & '0;
`endif

endmodule

// File: tb/tb_rt_ibex_pcs_stack.sv
module tb_rt_ibex_pcs_stack;

    localparam int NR = 9;
    localparam int DWD = 32;
    localparam int SD = 8;
    localparam int LW = 8;
    localparam int W = NR * DWD;
    localparam int DPW = $clog2(SD + 1);

    logic           clk = 1'b0;
    logic           rst_ni = 1'b0;
    logic           irq_ack = 1'b0;
    logic [LW-1:0]  irq_level = '0;
    logic [W-1:0]   store_data = '0;
    logic           next_mret = 1'b0;
    logic           clear_err = 1'b0;
    logic [W-1:0]   restore_data;
    logic [LW-1:0]  restore_level;
    logic           restore_en, busy, full, empty, overflow, underflow;
    logic [DPW-1:0] depth;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0]  q_data [$];
    logic [LW-1:0] q_lvl [$];
    bit            e_ovf = 0;
    bit            e_unf = 0;
    logic [LW-1:0] e_lvl = '0;

    rt_ibex_pcs_stack #(
        .NrSavedRegs   (NR),
        .DataWidth     (DWD),
        .StackDepth    (SD),
        .IrqLevelWidth (LW)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .irq_ack_i       (irq_ack),
        .irq_level_i     (irq_level),
        .store_data_i    (store_data),
        .next_mret_i     (next_mret),
        .restore_data_o  (restore_data),
        .restore_level_o (restore_level),
        .restore_en_o    (restore_en),
        .busy_o          (busy),
        .full_o          (full),
        .empty_o         (empty),
        .depth_o         (depth),
        .overflow_o      (overflow),
        .underflow_o     (underflow),
        .clear_err_i     (clear_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rand_frame();
        logic [W-1:0] f;
        for (int i = 0; i < NR; i++) f[i*DWD +: DWD] = $urandom;
        return f;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, W'(busy), W'(0));
        check({tag, "_en"}, W'(restore_en), W'(0));
        check({tag, "_data"}, restore_data, '0);
        check({tag, "_depth"}, W'(depth), W'(q_data.size()));
        check({tag, "_full"}, W'(full), W'(q_data.size() == SD));
        check({tag, "_empty"}, W'(empty), W'(q_data.size() == 0));
        check({tag, "_ovf"}, W'(overflow), W'(e_ovf));
        check({tag, "_unf"}, W'(underflow), W'(e_unf));
        check({tag, "_lvl"}, W'(restore_level), W'(e_lvl));
    endtask

    // One request cycle from IDLE, then follow the resulting operation to completion.
    task automatic op(input string tag, input bit ack, input bit mret, input bit clr,
                      input logic [LW-1:0] lvl);
        logic [W-1:0] d;
        d = rand_frame();
        irq_ack = ack;
        next_mret = mret;
        clear_err = clr;
        store_data = d;
        irq_level = lvl;
        step();
        irq_ack = 1'b0;
        next_mret = 1'b0;
        clear_err = 1'b0;
        irq_level = LW'($urandom);
        if (clr) begin
            e_ovf = 0;
            e_unf = 0;
        end
        if (ack && q_data.size() == SD) e_ovf = 1;
        else if (ack) begin
            check({tag, "_store_busy"}, W'(busy), W'(1));
            step();
            store_data = rand_frame();
            q_data.push_back(d);
            q_lvl.push_back(lvl);
        end else if (mret && q_data.size() == 0) e_unf = 1;
        else if (mret) begin
            check({tag, "_req_en"}, W'(restore_en), W'(0));
            step();
            check({tag, "_rsp_en"}, W'(restore_en), W'(1));
            check({tag, "_rsp_data"}, restore_data, q_data[$]);
`ifdef RT_IBEX_PCS_LEVEL_TAG_EN
            e_lvl = q_lvl[$];
`endif
            check({tag, "_rsp_lvl"}, W'(restore_level), W'(e_lvl));
            step();
            void'(q_data.pop_back());
            void'(q_lvl.pop_back());
        end
        check_idle(tag);
    endtask

    initial begin
        #12;
        check_idle("reset");
        step();
        rst_ni = 1'b1;
        step();
        check_idle("post_reset");

        op("t1_pushA", 1, 0, 0, 8'h03);
        op("t1_pushB", 1, 0, 0, 8'h05);
        op("t1_pop1", 0, 1, 0, 8'h00);
        op("t1_pop2", 0, 1, 0, 8'h00);

        for (int i = 0; i < SD + 1; i++) op("t2_push", 1, 0, 0, LW'(i + 1));
        check("t2_overflow", W'(overflow), W'(1));
        op("t2_ovf_clear_and_set", 1, 0, 1, 8'h00);
        for (int i = 0; i < SD; i++) op("t2_pop", 0, 1, 0, 8'h00);
        op("t2_clear", 0, 0, 1, 8'h00);

        op("t3_underflow", 0, 1, 0, 8'h00);
        op("t3_clear", 0, 0, 1, 8'h00);

        op("t4_push1", 1, 0, 0, 8'h21);
        op("t4_both", 1, 1, 0, 8'h22);
        op("t4_pop", 0, 1, 0, 8'h00);

        op("t6_push12", 1, 0, 0, 8'h12);
        op("t6_push34", 1, 0, 0, 8'h34);
        op("t6_pop34", 0, 1, 0, 8'h00);
        op("t6_pop12", 0, 1, 0, 8'h00);

        next_mret = 1'b1;
        step();
        next_mret = 1'b0;
        check("t5_busy_req", W'(busy), W'(1));
        rst_ni = 1'b0;
        #1;
        check("t5_en_in_reset", W'(restore_en), W'(0));
        step();
        check("t5_en_after_edge", W'(restore_en), W'(0));
        rst_ni = 1'b1;
        q_data.delete();
        q_lvl.delete();
        e_ovf = 0;
        e_unf = 0;
        e_lvl = '0;
        step();
        check_idle("t5_after_reset");

        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 9);
            op("rand", r < 4 || r == 8, (r >= 4 && r < 8) || r == 8, r == 9 || $urandom_range(0, 15) == 0,
               LW'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
